// File: rtl/cnu_msg_gen.sv
// Check-node message generator for offset min-sum decoding. It takes one min/min2/index/sign set
// and emits D check-to-variable messages, one per handshake.
module cnu_msg_gen #(
    parameter int data_w = 8,
    parameter int idx_w  = 8,
    parameter int D      = 5,
    parameter int OFFSET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] min,
    input  logic [data_w-1:0] min2,
    input  logic [idx_w-1:0]  min_idx,
    input  logic [D-1:0]      signs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w-1:0] out_mag,
    output logic              out_sign,
    output logic [idx_w-1:0]  out_idx,
    output logic              done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [idx_w-1:0]  LAST_K = idx_w'(D - 1);
    localparam logic [idx_w-1:0]  DEG    = idx_w'(D);
    localparam logic [data_w-1:0] OFF    = data_w'(OFFSET);

    state_t            state_reg, state_next;
    logic [idx_w-1:0]  k_reg, k_next;
    logic [data_w-1:0] min_reg, min2_reg;
    logic [idx_w-1:0]  min_idx_reg;
    logic [D-1:0]      signs_reg;
    logic              parity_reg;
    logic              done_reg;

    logic              last_hs;
    logic              accept;
    logic [data_w-1:0] sel;
    logic [D-1:0]      sign_hit;
    logic              sign_k;

    assign out_valid = (state_reg == EMIT);
    assign last_hs   = out_valid && out_ready && (k_reg == LAST_K);
    // The final handshake frees the slot, so a new set may enter in the same cycle.
    assign in_ready  = (state_reg == IDLE) || last_hs;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = EMIT;
                    k_next     = '0;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (k_reg == LAST_K) begin
                        k_next     = '0;
                        state_next = accept ? EMIT : IDLE;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            min_reg     <= '0;
            min2_reg    <= '0;
            min_idx_reg <= '0;
            signs_reg   <= '0;
            parity_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            done_reg  <= last_hs;
            if (accept) begin
                min_reg     <= min;
                min2_reg    <= min2;
                min_idx_reg <= min_idx;
                signs_reg   <= signs;
                parity_reg  <= ^signs;
            end
        end
    end

    // One-hot pick of signs[k] avoids indexing with the wider counter.
    for (genvar gi = 0; gi < D; gi++) begin : g_sign
        assign sign_hit[gi] = signs_reg[gi] && (k_reg == idx_w'(gi));
    end
    assign sign_k = |sign_hit;

    // A padded index (>= D) never matches k, so every edge then gets min.
    assign sel = ((min_idx_reg < DEG) && (k_reg == min_idx_reg)) ? min2_reg : min_reg;

    assign out_mag  = (out_valid && (sel > OFF)) ? (sel - OFF) : '0;
    assign out_sign = out_valid && (parity_reg ^ sign_k);
    assign out_idx  = out_valid ? k_reg : '0;
    assign done     = done_reg;

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Bench for cnu_msg_gen: directed sets, backpressure, back-to-back, reset abort, then random sets
// compared against an arithmetic reference.
module tb_cnu_msg_gen;

    localparam int DW     = 8;
    localparam int IW     = 8;
    localparam int D      = 5;
    localparam int OFFSET = 1;

    typedef struct {
        int mn;
        int mn2;
        int mi;
        int sg;
    } set_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] min = '0;
    logic [DW-1:0] min2 = '0;
    logic [IW-1:0] min_idx = '0;
    logic [D-1:0]  signs = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_mag;
    logic          out_sign;
    logic [IW-1:0] out_idx;
    logic          done;

    int total = 0;
    int bad   = 0;
    int set_no = 0;

    cnu_msg_gen #(.data_w(DW), .idx_w(IW), .D(D), .OFFSET(OFFSET)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .min(min), .min2(min2), .min_idx(min_idx), .signs(signs),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mag(out_mag), .out_sign(out_sign), .out_idx(out_idx),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the edge that owns the minimum sees min2, every other edge sees min;
    // the offset is subtracted with a floor at zero; the sign excludes the edge's own sign.
    function automatic int ref_mag(input set_t s, input int k);
        int sel;
        sel = (s.mi < D && s.mi == k) ? s.mn2 : s.mn;
        return (sel > OFFSET) ? sel - OFFSET : 0;
    endfunction

    function automatic int ref_sign(input set_t s, input int k);
        int par;
        par = 0;
        for (int i = 0; i < D; i++) par ^= (s.sg >> i) & 1;
        return par ^ ((s.sg >> k) & 1);
    endfunction

    function automatic set_t mk(input int mn, input int mn2, input int mi, input int sg);
        set_t s;
        s.mn = mn; s.mn2 = mn2; s.mi = mi; s.sg = sg;
        return s;
    endfunction

    function automatic set_t rnd_set();
        return mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7),
                  $urandom_range(0, 31));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input set_t s);
        min      = DW'(s.mn);
        min2     = DW'(s.mn2);
        min_idx  = IW'(s.mi);
        signs    = D'(s.sg);
        in_valid = 1'b1;
    endtask

    task automatic accept(input set_t s);
        present(s);
        #1;
        check("accept_in_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic check_msg(input string tag, input set_t s, input int k);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_idx"}, out_idx, k);
        check({tag, "_mag"}, out_mag, ref_mag(s, k));
        check({tag, "_sign"}, out_sign, ref_sign(s, k));
    endtask

    // Walks one set through all D messages; a stall of stall_n cycles is inserted at stall_k.
    task automatic drain(input set_t s, input int stall_k, input int stall_n,
                         input bit first_done, input bit chain, input set_t nxt);
        int cyc;
        cyc = 0;
        for (int k = 0; k < D; k++) begin
            for (int c = 0; c < ((k == stall_k) ? stall_n : 0); c++) begin
                out_ready = 1'b0;
                #1;
                check_msg("stall", s, k);
                check("stall_in_ready", in_ready, 0);
                check("stall_done", done, (first_done && cyc == 0) ? 1 : 0);
                cyc++;
                next_cycle();
            end
            out_ready = 1'b1;
            if (k == D - 1 && chain) present(nxt);
            #1;
            check_msg("msg", s, k);
            check("msg_in_ready", in_ready, (k == D - 1) ? 1 : 0);
            check("msg_done", done, (first_done && cyc == 0) ? 1 : 0);
            $display("set %0d idx %0d mag %0d sign %0d", set_no, out_idx, out_mag, out_sign);
            cyc++;
            next_cycle();
            if (k == D - 1 && chain) in_valid = 1'b0;
        end
        set_no++;
    endtask

    task automatic finish_idle();
        check("end_done", done, 1);
        check("end_valid", out_valid, 0);
        next_cycle();
        check("idle_done", done, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        set_t a, b, cur, nxt;
        bit chained, chain;

        // Power-on reset.
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_mag", out_mag, 0);
        check("rst_sign", out_sign, 0);
        check("rst_idx", out_idx, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);

        // Basic set: mags 5,5,8,5,5 and signs 1,0,1,0,0.
        a = mk(6, 9, 2, 5'b00101);
        accept(a);
        drain(a, -1, 0, 0, 0, a);
        finish_idle();

        // Offset saturates at zero.
        a = mk(0, 1, 0, 5'b11010);
        accept(a);
        drain(a, -1, 0, 0, 0, a);
        finish_idle();

        // Padded index: every edge uses min.
        a = mk(3, 7, 5, 5'b01110);
        accept(a);
        drain(a, -1, 0, 0, 0, a);
        finish_idle();

        // Equal minima.
        a = mk(4, 4, 3, 5'b10001);
        accept(a);
        drain(a, -1, 0, 0, 0, a);
        finish_idle();

        // Backpressure: three stall cycles at idx 1.
        a = mk(6, 9, 2, 5'b00101);
        accept(a);
        drain(a, 1, 3, 0, 0, a);
        finish_idle();

        // Back-to-back: the second set enters on the idx-4 handshake.
        a = mk(10, 20, 4, 5'b11100);
        b = mk(3, 7, 1, 5'b00011);
        accept(a);
        drain(a, -1, 0, 0, 1, b);
        drain(b, -1, 0, 1, 0, b);
        finish_idle();

        // Reset during idx 2 aborts the set.
        a = mk(50, 60, 2, 5'b10101);
        accept(a);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_msg("pre_abort", a, k);
            next_cycle();
        end
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_mag", out_mag, 0);
        check("abort_sign", out_sign, 0);
        check("abort_idx", out_idx, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        check("abort_in_ready", in_ready, 1);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_stale", out_valid, 0);
            check("abort_no_done", done, 0);
            next_cycle();
        end
        set_no++;

        // Random sets with random stalls and random chaining.
        chained = 1'b0;
        cur = rnd_set();
        for (int i = 0; i < 40; i++) begin
            if (!chained) accept(cur);
            chain = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            nxt = rnd_set();
            drain(cur, $urandom_range(0, D - 1), $urandom_range(0, 3), chained, chain, nxt);
            if (!chain) finish_idle();
            chained = chain;
            cur = nxt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnu_msg_gen.md
CNU_MSG_GEN -- requirements
Module: cnu_msg_gen

Interface
REQ-001 SHALL have parameter data_w, default 8, the magnitude width of min, min2 and out_mag.
REQ-002 SHALL have parameter idx_w, default 8, the width of min_idx, out_idx and the internal message counter.
REQ-003 SHALL have parameter D, default 5, the check-node degree, i.e. the number of messages emitted per set.
REQ-004 SHALL have parameter OFFSET, default 1, the offset min-sum correction subtracted from each magnitude.
REQ-005 SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-006 SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, asserted when a min/min2/min_idx/signs set is presented.
REQ-008 SHALL have port in_ready, output, 1, asserted when the block can accept a set this cycle.
REQ-009 SHALL have port min, input, data_w, the smallest input magnitude.
REQ-010 SHALL have port min2, input, data_w, the second-smallest input magnitude.
REQ-011 SHALL have port min_idx, input, idx_w, the edge position of min.
REQ-012 SHALL have port signs, input, D, the per-edge input sign bits, where bit k belongs to edge k.
REQ-013 SHALL have port out_valid, output, 1, asserted when an output message is held on out_mag, out_sign and out_idx.
REQ-014 SHALL have port out_ready, input, 1, the downstream acceptance of the current message.
REQ-015 SHALL have port out_mag, output, data_w, the check-to-variable message magnitude.
REQ-016 SHALL have port out_sign, output, 1, the check-to-variable message sign (1 = negative).
REQ-017 SHALL have port out_idx, output, idx_w, the edge index k of the current message.
REQ-018 SHALL have port done, output, 1, a one-cycle pulse marking the cycle after the last message of a set is accepted.

Function
REQ-019 SHALL accept a set when in_valid and in_ready are both high on a clock edge, and SHALL then latch min, min2, min_idx and signs, and store parity = XOR of all signs.
REQ-020 SHALL implement a two-state FSM: IDLE and EMIT.
- IDLE -> EMIT on accept.
- EMIT -> IDLE when message k = D-1 is handshaken with no new accept in the same cycle.
- EMIT -> EMIT when that final handshake coincides with an accept.
REQ-021 SHALL drive in_ready high in IDLE, and combinationally high in EMIT only when k = D-1 and out_valid and out_ready are both high; it SHALL be low otherwise.
REQ-022 SHALL assert out_valid in the cycle after accept (latency 1), with out_idx = 0.
REQ-023 SHALL advance k by 1 on each out_valid and out_ready handshake, for k = 0 .. D-1, one message per cycle at most.
REQ-024 SHALL hold out_valid, out_mag, out_sign and out_idx stable while out_valid is high and out_ready is low.
REQ-025 SHALL compute the raw magnitude as sel = min2 when k == min_idx, and sel = min otherwise.
REQ-026 SHALL compute out_mag = sel - OFFSET when sel > OFFSET, and 0 otherwise, with no wrap-around.
REQ-027 SHALL compute out_sign = parity XOR signs[k].
REQ-028 SHALL use sel = min for every k when min_idx >= D (padded index).
REQ-029 SHALL, on a back-to-back accept coinciding with the final handshake, drive message k = 0 of the new set in the next cycle, with no bubble and no mixing of fields between sets.
REQ-030 SHALL pulse done for exactly one cycle after the k = D-1 handshake, including in the back-to-back case.
REQ-031 SHALL ignore in_valid while in_ready is low; the upstream SHALL hold its data until accepted.
REQ-032 SHALL handle min == min2 correctly: all messages carry the same magnitude.

Reset
REQ-033 SHALL, while rst is low, force state = IDLE, k = 0, out_valid = 0, out_mag = 0, out_sign = 0, out_idx = 0 and done = 0, and hold latched data at 0.
REQ-034 SHALL abort any in-progress set when rst is asserted mid-EMIT, without emitting its remaining messages; in_ready SHALL be 1 in the first cycle after rst is released.

Verification
REQ-035 Basic set: D=5, OFFSET=1, min=6, min2=9, min_idx=2, signs=5'b00101, out_ready=1 -> out_mag 5,5,8,5,5; out_sign 1,0,1,0,0; out_idx 0..4 on consecutive cycles; done one cycle after idx 4.
REQ-036 Saturation: min=0, min2=1, min_idx=0, OFFSET=1 -> all out_mag = 0.
REQ-037 Padded index: min_idx=5, min=3, min2=7 -> all out_mag = 2.
REQ-038 Backpressure: hold out_ready low for 3 cycles at idx 1 -> out_idx stays 1 with stable data, then resumes at 2; in_ready stays 0 throughout.
REQ-039 Back-to-back: second set valid during the idx-4 handshake -> in_ready=1 in that cycle; next cycle shows idx 0 of the new set; done pulses once.
REQ-040 Reset mid-EMIT at idx 2 -> out_valid=0 and all outputs 0 immediately; in_ready=1 after release; no stale messages appear.
